// File: rtl/float_pkg.sv
// IEEE 754 single-precision field layout shared by the float conversion blocks.
package float_pkg;

    localparam int unsigned EXPONENT_BITS = 8;
    localparam int unsigned FRACTION_BITS = 23;
    localparam int unsigned BIAS          = 127;

    typedef struct packed {
        logic                     sign;
        logic [EXPONENT_BITS-1:0] exponent;
        logic [FRACTION_BITS-1:0] fraction;
    } float;

endpackage

// File: rtl/fp_to_int_conv_if.sv
// Operand/result handshake bundle for the float-to-integer converter.
interface fp_to_int_conv_if;

    logic           in_valid;
    logic           in_ready;
    float_pkg::float in_data;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_data;
    logic           out_overflow;
    logic           out_invalid;
    logic           out_inexact;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_overflow, out_invalid, out_inexact
    );

    // Converter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_overflow, out_invalid, out_inexact
    );

endinterface

// File: rtl/fp_to_int_conv.sv
// Iterative single-precision float to signed 32-bit integer converter.
// Rounds toward zero, one magnitude shift per clock; saturates on overflow.
module fp_to_int_conv
    import float_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    fp_to_int_conv_if.slave  bus
);

    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [EXPONENT_BITS-1:0] EXP_MAX = '1;
    localparam logic [EXPONENT_BITS-1:0] EXP_ONE = EXPONENT_BITS'(BIAS);
    localparam logic [EXPONENT_BITS-1:0] EXP_LSB = EXPONENT_BITS'(BIAS + FRACTION_BITS);
    localparam logic [EXPONENT_BITS-1:0] EXP_SAT = EXPONENT_BITS'(BIAS + 31);

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

    logic [1:0]       state_q,     state_d;
    logic [31:0]      mag_q,       mag_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             sticky_q,    sticky_d;
    logic             left_q,      left_d;
    logic             sign_q,      sign_d;
    logic [31:0]      data_q,      data_d;
    logic             ovf_q,       ovf_d;
    logic             inv_q,       inv_d;
    logic             inx_q,       inx_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    float             op_c;
    logic [31:0]      m_ext_c;
    logic [31:0]      mag_shift_c;
    logic             sticky_shift_c;
    logic [CNT_W-1:0] n_c;
    logic             go_shift_c;

    function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] mag);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

    function automatic logic [31:0] sat_value(input logic neg);
        return neg ? SAT_NEG : SAT_POS;
    endfunction

    assign op_c           = bus.in_data;
    assign m_ext_c        = {8'd0, 1'b1, op_c.fraction};
    assign mag_shift_c    = left_q ? (mag_q << 1) : (mag_q >> 1);
    assign sticky_shift_c = sticky_q | (~left_q & mag_q[0]);

    // Next-state, datapath and output decode
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        left_d      = left_q;
        sign_d      = sign_q;
        data_d      = data_q;
        ovf_d       = ovf_q;
        inv_d       = inv_q;
        inx_d       = inx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        n_c         = '0;
        go_shift_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sign_d   = op_c.sign;
                    mag_d    = m_ext_c;
                    sticky_d = 1'b0;
                    left_d   = 1'b0;
                    data_d   = '0;
                    ovf_d    = 1'b0;
                    inv_d    = 1'b0;
                    inx_d    = 1'b0;

                    if (op_c.exponent == EXP_MAX && op_c.fraction != '0) begin
                        inv_d = 1'b1;
                    end else if (op_c.exponent == EXP_MAX) begin
                        ovf_d  = 1'b1;
                        data_d = sat_value(op_c.sign);
                    end else if (op_c.exponent == '0 && op_c.fraction == '0) begin
                        data_d = '0;
                    end else if (op_c.exponent < EXP_ONE) begin
                        inx_d = 1'b1;
                    end else if (op_c.exponent >= EXP_SAT) begin
                        // -2^31 is the only representable value at or above 2^31
                        if (op_c.sign && op_c.exponent == EXP_SAT && op_c.fraction == '0) begin
                            data_d = SAT_NEG;
                        end else begin
                            ovf_d  = 1'b1;
                            data_d = sat_value(op_c.sign);
                        end
                    end else if (op_c.exponent >= EXP_LSB) begin
                        left_d = 1'b1;
                        n_c    = CNT_W'(op_c.exponent - EXP_LSB);
                        if (n_c == '0) begin
                            data_d = apply_sign(op_c.sign, m_ext_c);
                        end else begin
                            go_shift_c = 1'b1;
                        end
                    end else begin
                        n_c        = CNT_W'(EXP_LSB - op_c.exponent);
                        go_shift_c = 1'b1;
                    end

                    cnt_d      = n_c;
                    in_ready_d = 1'b0;
                    if (go_shift_c) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end

            S_SHIFT: begin
                mag_d    = mag_shift_c;
                sticky_d = sticky_shift_c;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    data_d      = apply_sign(sign_q, mag_shift_c);
                    inx_d       = sticky_shift_c;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mag_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            left_q      <= 1'b0;
            sign_q      <= 1'b0;
            data_q      <= '0;
            ovf_q       <= 1'b0;
            inv_q       <= 1'b0;
            inx_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            left_q      <= left_d;
            sign_q      <= sign_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
            inv_q       <= inv_d;
            inx_q       <= inx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = data_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_invalid  = inv_q;
    assign bus.out_inexact  = inx_q;

endmodule
